// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// 32 shift-add or shift-subtract iterations on magnitudes, then a sign fix-up cycle.
module muldiv_hilo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_res_q, neg_res_d;
   logic                 x_neg_q, x_neg_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   logic                 x_sgn, y_sgn;
   logic [WIDTH-1:0]     x_mag, y_mag;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift, div_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo, rem, quo_fix, rem_fix, x_raw;

   // Signs only matter for the signed ops (op[0] == 0).
   assign x_sgn = ~op[0] & x[WIDTH-1];
   assign y_sgn = ~op[0] & y[WIDTH-1];
   assign x_mag = x_sgn ? -x : x;
   assign y_mag = y_sgn ? -y : y;

   // Multiply: acc = {partial, multiplier}; add multiplicand into the top, shift right.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
   assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift - {1'b0, b_q};
   assign div_next  = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

   assign prod_fix = neg_res_q ? -acc_q : acc_q;
   assign quo      = acc_q[WIDTH-1:0];
   assign rem      = acc_q[2*WIDTH-1:WIDTH];
   assign quo_fix  = neg_res_q ? -quo : quo;
   assign rem_fix  = x_neg_q ? -rem : rem;
   assign x_raw    = x_neg_q ? -a_q : a_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      x_neg_d   = x_neg_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (we_hi) hi_d = wdata;
            if (we_lo) lo_d = wdata;
            if (start) begin
               state_d   = StRun;
               cnt_d     = '0;
               is_div_d  = op[1];
               neg_res_d = x_sgn ^ y_sgn;
               x_neg_d   = x_sgn;
               a_d       = x_mag;
               b_d       = y_mag;
               acc_d     = {{WIDTH{1'b0}}, (op[1] ? x_mag : y_mag)};
            end
         end
         StRun: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) state_d = StFix;
         end
         StFix: begin
            done_d  = 1'b1;
            state_d = StIdle;
            if (!is_div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (b_q == '0) begin
               // Divide by zero returns the dividend as issued and an all-ones quotient.
               hi_d = x_raw;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         x_neg_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         x_neg_q   <= x_neg_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed and randomized bench for muldiv_hilo against an arithmetic reference model.
module tb_muldiv_hilo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] x, y;
   logic        we_hi, we_lo;
   logic [31:0] wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;

   muldiv_hilo #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .x     (x),
      .y     (y),
      .we_hi (we_hi),
      .we_lo (we_lo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns {hi, lo} from the architectural rules.
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb;
      int ia, ib;
      case (o)
         2'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
         end
         2'd1: return {32'h0, a} * {32'h0, b};
         2'd2: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            ia = $signed(a);
            ib = $signed(b);
            return {32'(ia % ib), 32'(ia / ib)};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_done(output int k);
      k = 0;
      while (k < 40 && !done) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Issue one op; optionally inject ignored starts and MTHI/MTLO while busy.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input string tag);
      logic [63:0] exp;
      logic [31:0] hi0, lo0;
      bit held;
      int k;
      exp = ref_model(o, a, b);
      @(negedge clk);
      hi0 = hi;
      lo0 = lo;
      start = 1'b1; op = o; x = a; y = b;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); x = $urandom; y = $urandom;
      chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
      held = 1'b1;
      k = 0;
      while (k < 40 && !done) begin
         if (hi !== hi0 || lo !== lo0) held = 1'b0;
         start = inject && (k == 5 || k == 20);
         if (start) begin
            op = 2'($urandom); x = $urandom; y = $urandom;
         end
         we_hi = inject && (k == 10);
         we_lo = inject && (k == 10);
         wdata = $urandom;
         @(negedge clk);
         k++;
      end
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      chk({tag, " latency"}, 64'(k), 64'd33);
      chk({tag, " hold_during_run"}, 64'(held), 64'd1);
      chk({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
      chk({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
      chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
      repeat (inject ? 3 : 1) begin
         @(negedge clk);
         chk({tag, " done_single"}, {62'h0, busy, done}, 64'd0);
      end
   endtask

   initial begin
      int k;
      rst_n = 1'b0; start = 1'b0; op = 2'd0; x = '0; y = '0;
      we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      chk("reset_state", {busy, done, hi, lo}, 66'h0);
      rst_n = 1'b1;

      // T2, T3
      run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "t2_multu_max");
      chk("t2_hi_const", 64'(hi), 64'hFFFFFFFE);
      chk("t2_lo_const", 64'(lo), 64'h00000001);
      run_op(2'd0, 32'hFFFFFFF9, 32'd3, 1'b0, "t3_mult");
      chk("t3_mult_lo_const", 64'(lo), 64'hFFFFFFEB);
      run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, "t3_div");
      chk("t3_div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

      // T1: reset mid-run aborts the op
      @(negedge clk);
      start = 1'b1; op = 2'd1; x = 32'd12345; y = 32'd678;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t1_reset_midrun", {busy, done, hi, lo}, 66'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t1_stays_idle", {busy, done}, 64'd0);
      run_op(2'd1, 32'd12345, 32'd678, 1'b0, "t1_after_reset");

      // T4
      run_op(2'd3, 32'd100, 32'd0, 1'b0, "t4_divu_zero");
      chk("t4_divu_zero_const", {hi, lo}, 64'h00000064_FFFFFFFF);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, "t4_div_ovf");
      chk("t4_div_ovf_const", {hi, lo}, 64'h00000000_80000000);
      run_op(2'd2, 32'hFFFFFF9C, 32'd0, 1'b0, "t4_div_neg_zero");

      // T5
      run_op(2'd2, 32'd1000, 32'hFFFFFFF9, 1'b1, "t5_ignored_starts");

      // T6
      @(negedge clk);
      we_hi = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      we_hi = 1'b0;
      chk("t6_mthi", 64'(hi), 64'h1234);
      we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hAAAA5555;
      @(negedge clk);
      we_hi = 1'b0; we_lo = 1'b0;
      chk("t6_mthi_mtlo", {hi, lo}, 64'hAAAA5555_AAAA5555);
      start = 1'b1; op = 2'd1; x = 32'd2; y = 32'd3; we_hi = 1'b1; wdata = 32'hCAFE;
      @(negedge clk);
      start = 1'b0; we_hi = 1'b0;
      chk("t6_same_edge_write", 64'(hi), 64'hCAFE);
      chk("t6_same_edge_busy", 64'(busy), 64'd1);
      wait_done(k);
      chk("t6_latency", 64'(k), 64'd33);
      chk("t6_result", {hi, lo}, 64'h00000000_00000006);

      // Randomized ops with corner operands
      for (int i = 0; i < 600; i++) begin
         run_op(2'(i % 4), pick(), pick(), 1'b0, $sformatf("rand%0d_op%0d", i, i % 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
